// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry layout, register-file widths and
// the helper that decides whether a retiring entry updates architectural state.
package reorder_buffer_pkg;

  localparam int PHYS_W = 6;
  localparam int ARCH_W = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispredict;
    logic              store;
    logic              regwrite;
    logic [ARCH_W-1:0] arch_dest;
    logic [PHYS_W-1:0] phys_dest;
    logic [PHYS_W-1:0] old_phys;
    logic [31:0]       pc;
    logic [31:0]       instr_num;
    logic [31:0]       target;
  } rob_entry_t;

  // Architectural register 0 is hardwired, so writes to it never touch the RRAT.
  function automatic logic writes_arch(input logic regwrite, input logic [ARCH_W-1:0] arch_dest);
    return regwrite && (arch_dest != {ARCH_W{1'b0}});
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Head/tail pointer pair with an extra wrap bit; derives full, empty and
// occupancy from the registered pointers.
module rob_ptr
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           clear,
  input  logic           inc_tail,
  input  logic           inc_head,
  output logic [IDX_W:0] head_ptr,
  output logic [IDX_W:0] tail_ptr,
  output logic [IDX_W:0] count,
  output logic           full,
  output logic           empty
);

  localparam logic [IDX_W:0] PTR_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0] PTR_ZERO = {(IDX_W+1){1'b0}};

  logic [IDX_W:0] head_r;
  logic [IDX_W:0] tail_r;

  // Pointer registers; clear takes priority over any advance in the same cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_r <= PTR_ZERO;
      tail_r <= PTR_ZERO;
    end else if (clear) begin
      head_r <= PTR_ZERO;
      tail_r <= PTR_ZERO;
    end else begin
      if (inc_head) head_r <= head_r + PTR_ONE;
      if (inc_tail) tail_r <= tail_r + PTR_ONE;
    end
  end

  assign head_ptr = head_r;
  assign tail_ptr = tail_r;
  assign count    = tail_r - head_r;
  assign empty    = (head_r == tail_r);
  assign full     = (head_r[IDX_W-1:0] == tail_r[IDX_W-1:0]) && (head_r[IDX_W] != tail_r[IDX_W]);

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer between rename and the RRAT/free list/LSQ.
// Define REORDER_BUFFER_RECOVERY_EN to enable mispredict-triggered recovery.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              alloc_valid,
  input  logic [31:0]       alloc_instr_num,
  input  logic [31:0]       alloc_pc,
  input  logic [ARCH_W-1:0] alloc_arch_dest,
  input  logic [PHYS_W-1:0] alloc_phys_dest,
  input  logic [PHYS_W-1:0] alloc_old_phys,
  input  logic              alloc_regwrite,
  input  logic              alloc_store,
  output logic [IDX_W-1:0]  alloc_idx,
  output logic              rob_halt,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_idx,
  input  logic              cmpl_mispredict,
  input  logic [31:0]       cmpl_target,
  output logic              commit_valid,
  output logic [ARCH_W-1:0] commit_arch_dest,
  output logic [PHYS_W-1:0] commit_phys,
  output logic              commit_regwrite,
  output logic              free_valid,
  output logic [PHYS_W-1:0] free_phys,
  output logic              commit_store,
  output logic [31:0]       commit_instr_num,
  output logic [31:0]       head_instr_num,
  output logic              recover,
  output logic [31:0]       recover_pc,
  output logic [IDX_W:0]    count
);

  rob_entry_t       rob_r [DEPTH];
  rob_entry_t       head_s;
  rob_entry_t       alloc_entry_s;
  logic [IDX_W:0]   head_ptr_s;
  logic [IDX_W:0]   tail_ptr_s;
  logic [IDX_W:0]   count_s;
  logic [IDX_W-1:0] head_idx_s;
  logic [IDX_W-1:0] tail_idx_s;
  logic             full_s;
  logic             empty_s;
  logic             alloc_fire_s;
  logic             commit_fire_s;
  logic             recover_fire_s;
  logic             clear_s;
  logic             unused_pc_s;

  assign head_idx_s    = head_ptr_s[IDX_W-1:0];
  assign tail_idx_s    = tail_ptr_s[IDX_W-1:0];
  assign head_s        = rob_r[head_idx_s];
  assign alloc_fire_s  = alloc_valid && !full_s;
  assign commit_fire_s = head_s.valid && head_s.done && !FLUSH;
  assign clear_s       = FLUSH || recover_fire_s;
  assign unused_pc_s   = ^head_s.pc;

`ifdef REORDER_BUFFER_RECOVERY_EN
  assign recover_fire_s = commit_fire_s && head_s.mispredict;
`else
  logic unused_recovery_s;
  assign recover_fire_s    = 1'b0;
  assign unused_recovery_s = ^{cmpl_mispredict, cmpl_target, head_s.mispredict, head_s.target};
`endif

  rob_ptr #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ptr (
    .CLK      (CLK),
    .RESET    (RESET),
    .clear    (clear_s),
    .inc_tail (alloc_fire_s),
    .inc_head (commit_fire_s),
    .head_ptr (head_ptr_s),
    .tail_ptr (tail_ptr_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Entry presented by rename, written at the tail
  always_comb begin
    alloc_entry_s           = {$bits(rob_entry_t){1'b0}};
    alloc_entry_s.valid     = 1'b1;
    alloc_entry_s.store     = alloc_store;
    alloc_entry_s.regwrite  = alloc_regwrite;
    alloc_entry_s.arch_dest = alloc_arch_dest;
    alloc_entry_s.phys_dest = alloc_phys_dest;
    alloc_entry_s.old_phys  = alloc_old_phys;
    alloc_entry_s.pc        = alloc_pc;
    alloc_entry_s.instr_num = alloc_instr_num;
  end

  // Entry storage: allocate at tail, mark completions, retire the head
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) rob_r[i] <= {$bits(rob_entry_t){1'b0}};
    end else if (clear_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_r[i].valid      <= 1'b0;
        rob_r[i].done       <= 1'b0;
        rob_r[i].mispredict <= 1'b0;
      end
    end else begin
      if (alloc_fire_s) rob_r[tail_idx_s] <= alloc_entry_s;
      if (cmpl_valid && rob_r[cmpl_idx].valid) begin
        rob_r[cmpl_idx].done <= 1'b1;
`ifdef REORDER_BUFFER_RECOVERY_EN
        rob_r[cmpl_idx].mispredict <= cmpl_mispredict;
        rob_r[cmpl_idx].target     <= cmpl_target;
`endif
      end
      // Retirement is last so it wins over a redundant completion of the head
      if (commit_fire_s) begin
        rob_r[head_idx_s].valid <= 1'b0;
        rob_r[head_idx_s].done  <= 1'b0;
      end
    end
  end

  // Registered retirement outputs, zeroed in cycles without a commit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      commit_valid     <= 1'b0;
      commit_arch_dest <= {ARCH_W{1'b0}};
      commit_phys      <= {PHYS_W{1'b0}};
      commit_regwrite  <= 1'b0;
      free_valid       <= 1'b0;
      free_phys        <= {PHYS_W{1'b0}};
      commit_store     <= 1'b0;
      commit_instr_num <= 32'h0000_0000;
      recover          <= 1'b0;
      recover_pc       <= 32'h0000_0000;
    end else begin
      commit_valid     <= commit_fire_s;
      commit_arch_dest <= commit_fire_s ? head_s.arch_dest : {ARCH_W{1'b0}};
      commit_phys      <= commit_fire_s ? head_s.phys_dest : {PHYS_W{1'b0}};
      commit_regwrite  <= commit_fire_s && writes_arch(head_s.regwrite, head_s.arch_dest);
      free_valid       <= commit_fire_s && writes_arch(head_s.regwrite, head_s.arch_dest);
      free_phys        <= commit_fire_s ? head_s.old_phys : {PHYS_W{1'b0}};
      commit_store     <= commit_fire_s && head_s.store;
      commit_instr_num <= commit_fire_s ? head_s.instr_num : 32'h0000_0000;
      recover          <= recover_fire_s;
`ifdef REORDER_BUFFER_RECOVERY_EN
      recover_pc       <= recover_fire_s ? head_s.target : 32'h0000_0000;
`else
      recover_pc       <= 32'h0000_0000;
`endif
    end
  end

  assign alloc_idx      = tail_idx_s;
  assign rob_halt       = full_s;
  assign count          = count_s;
  assign head_instr_num = empty_s ? 32'h0000_0000 : head_s.instr_num;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; recovery expectations
// follow REORDER_BUFFER_RECOVERY_EN.
module tb_reorder_buffer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FLUSH;
  logic        alloc_valid;
  logic [31:0] alloc_instr_num;
  logic [31:0] alloc_pc;
  logic [4:0]  alloc_arch_dest;
  logic [5:0]  alloc_phys_dest;
  logic [5:0]  alloc_old_phys;
  logic        alloc_regwrite;
  logic        alloc_store;
  logic [3:0]  alloc_idx;
  logic        rob_halt;
  logic        cmpl_valid;
  logic [3:0]  cmpl_idx;
  logic        cmpl_mispredict;
  logic [31:0] cmpl_target;
  logic        commit_valid;
  logic [4:0]  commit_arch_dest;
  logic [5:0]  commit_phys;
  logic        commit_regwrite;
  logic        free_valid;
  logic [5:0]  free_phys;
  logic        commit_store;
  logic [31:0] commit_instr_num;
  logic [31:0] head_instr_num;
  logic        recover;
  logic [31:0] recover_pc;
  logic [4:0]  count;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  reorder_buffer #(.DEPTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .alloc_valid(alloc_valid), .alloc_instr_num(alloc_instr_num), .alloc_pc(alloc_pc),
    .alloc_arch_dest(alloc_arch_dest), .alloc_phys_dest(alloc_phys_dest),
    .alloc_old_phys(alloc_old_phys), .alloc_regwrite(alloc_regwrite),
    .alloc_store(alloc_store), .alloc_idx(alloc_idx), .rob_halt(rob_halt),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_mispredict(cmpl_mispredict),
    .cmpl_target(cmpl_target), .commit_valid(commit_valid),
    .commit_arch_dest(commit_arch_dest), .commit_phys(commit_phys),
    .commit_regwrite(commit_regwrite), .free_valid(free_valid), .free_phys(free_phys),
    .commit_store(commit_store), .commit_instr_num(commit_instr_num),
    .head_instr_num(head_instr_num), .recover(recover), .recover_pc(recover_pc),
    .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [31:0] num, input logic [4:0] arch,
                           input logic [5:0] phys, input logic [5:0] old_p,
                           input logic rw, input logic st);
    alloc_valid     = v;
    alloc_instr_num = num;
    alloc_pc        = num << 2;
    alloc_arch_dest = arch;
    alloc_phys_dest = phys;
    alloc_old_phys  = old_p;
    alloc_regwrite  = rw;
    alloc_store     = st;
  endtask

  task automatic set_cmpl(input logic v, input logic [3:0] idx, input logic mp, input logic [31:0] tgt);
    cmpl_valid      = v;
    cmpl_idx        = idx;
    cmpl_mispredict = mp;
    cmpl_target     = tgt;
  endtask

  initial begin
    RESET = 1'b0;
    FLUSH = 1'b0;
    set_alloc(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    set_cmpl(1'b0, 4'd0, 1'b0, 32'd0);
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_halt", 32'(rob_halt), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_head_num", head_instr_num, 32'd0);
    chk("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    chk("rst_recover", 32'(recover), 32'd0);
    RESET = 1'b1;
    step();

    // Fill all 16 entries with no completions
    for (int i = 0; i < 16; i++) begin
      chk("fill_alloc_idx", 32'(alloc_idx), 32'(i));
      set_alloc(1'b1, 32'(100 + i), 5'd1, 6'd10, 6'd20, 1'b1, 1'b0);
      step();
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_halt", 32'(rob_halt), 32'd1);
    chk("full_alloc_idx_wrap", 32'(alloc_idx), 32'd0);
    step();
    chk("full_blocked_count", 32'(count), 32'd16);
    chk("full_head_num", head_instr_num, 32'd100);
    set_alloc(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    set_cmpl(1'b1, 4'd0, 1'b0, 32'd0);
    step();
    set_cmpl(1'b0, 4'd0, 1'b0, 32'd0);
    FLUSH = 1'b1;
    step();
    chk("flush_no_commit", 32'(commit_valid), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_halt", 32'(rob_halt), 32'd0);
    FLUSH = 1'b0;
    step();
    chk("flush_after_commit", 32'(commit_valid), 32'd0);
    chk("flush_head_num", head_instr_num, 32'd0);

    // Out-of-order completion, in-order retirement
    set_alloc(1'b1, 32'd200, 5'd1, 6'd10, 6'd20, 1'b1, 1'b0); step();
    set_alloc(1'b1, 32'd201, 5'd2, 6'd11, 6'd21, 1'b1, 1'b0); step();
    set_alloc(1'b1, 32'd202, 5'd4, 6'd12, 6'd22, 1'b1, 1'b0); step();
    set_alloc(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    set_cmpl(1'b1, 4'd2, 1'b0, 32'd0); step();
    chk("ooo_idx2_no_commit", 32'(commit_valid), 32'd0);
    set_cmpl(1'b1, 4'd0, 1'b0, 32'd0); step();
    chk("ooo_no_bypass", 32'(commit_valid), 32'd0);
    set_cmpl(1'b0, 4'd0, 1'b0, 32'd0); step();
    chk("ooo_c0_valid", 32'(commit_valid), 32'd1);
    chk("ooo_c0_num", commit_instr_num, 32'd200);
    chk("ooo_c0_arch", 32'(commit_arch_dest), 32'd1);
    chk("ooo_c0_phys", 32'(commit_phys), 32'd10);
    chk("ooo_c0_free", 32'(free_phys), 32'd20);
    chk("ooo_c0_count", 32'(count), 32'd2);
    step();
    chk("ooo_idx1_wait", 32'(commit_valid), 32'd0);
    chk("ooo_head_num", head_instr_num, 32'd201);
    set_cmpl(1'b1, 4'd1, 1'b0, 32'd0); step();
    chk("ooo_c1_pending", 32'(commit_valid), 32'd0);
    set_cmpl(1'b0, 4'd0, 1'b0, 32'd0); step();
    chk("ooo_c1_num", commit_instr_num, 32'd201);
    step();
    chk("ooo_c2_valid", 32'(commit_valid), 32'd1);
    chk("ooo_c2_num", commit_instr_num, 32'd202);
    step();
    chk("ooo_drained_valid", 32'(commit_valid), 32'd0);
    chk("ooo_drained_count", 32'(count), 32'd0);

    // RRAT update and free-list return
    chk("rrat_alloc_idx", 32'(alloc_idx), 32'd3);
    set_alloc(1'b1, 32'd300, 5'd3, 6'd40, 6'd3, 1'b1, 1'b0); step();
    set_alloc(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    set_cmpl(1'b1, 4'd3, 1'b0, 32'd0); step();
    set_cmpl(1'b0, 4'd0, 1'b0, 32'd0); step();
    chk("rrat_arch", 32'(commit_arch_dest), 32'd3);
    chk("rrat_phys", 32'(commit_phys), 32'd40);
    chk("rrat_regwrite", 32'(commit_regwrite), 32'd1);
    chk("rrat_free_valid", 32'(free_valid), 32'd1);
    chk("rrat_free_phys", 32'(free_phys), 32'd3);
    chk("rrat_store", 32'(commit_store), 32'd0);

    // Write to architectural r0 (also a store)
    set_alloc(1'b1, 32'd301, 5'd0, 6'd41, 6'd7, 1'b1, 1'b1); step();
    set_alloc(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    set_cmpl(1'b1, 4'd4, 1'b0, 32'd0); step();
    set_cmpl(1'b0, 4'd0, 1'b0, 32'd0); step();
    chk("r0_commit_valid", 32'(commit_valid), 32'd1);
    chk("r0_regwrite", 32'(commit_regwrite), 32'd0);
    chk("r0_free_valid", 32'(free_valid), 32'd0);
    chk("r0_store", 32'(commit_store), 32'd1);

    // Mispredicted branch at idx1
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    set_alloc(1'b1, 32'd400, 5'd5, 6'd50, 6'd5, 1'b1, 1'b0); step();
    set_alloc(1'b1, 32'd401, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0); step();
    set_alloc(1'b1, 32'd402, 5'd6, 6'd51, 6'd6, 1'b1, 1'b0);
    set_cmpl(1'b1, 4'd0, 1'b0, 32'd0); step();
    set_alloc(1'b1, 32'd403, 5'd7, 6'd52, 6'd7, 1'b1, 1'b0);
    set_cmpl(1'b1, 4'd1, 1'b1, 32'h0040_0100); step();
    chk("br_c0_num", commit_instr_num, 32'd400);
    chk("br_c0_recover", 32'(recover), 32'd0);
    chk("br_c0_count", 32'(count), 32'd3);
    set_alloc(1'b1, 32'd404, 5'd8, 6'd53, 6'd8, 1'b1, 1'b0);
    set_cmpl(1'b0, 4'd0, 1'b0, 32'd0); step();
    set_alloc(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("br_commit_valid", 32'(commit_valid), 32'd1);
    chk("br_commit_num", commit_instr_num, 32'd401);
`ifdef REORDER_BUFFER_RECOVERY_EN
    chk("br_recover", 32'(recover), 32'd1);
    chk("br_recover_pc", recover_pc, 32'h0040_0100);
    chk("br_count", 32'(count), 32'd0);
    step();
    chk("br_recover_pulse", 32'(recover), 32'd0);
    chk("br_after_count", 32'(count), 32'd0);
`else
    chk("br_recover", 32'(recover), 32'd0);
    chk("br_recover_pc", recover_pc, 32'd0);
    chk("br_count", 32'(count), 32'd3);
    step();
    chk("br_after_valid", 32'(commit_valid), 32'd0);
    chk("br_after_count", 32'(count), 32'd3);
`endif

    // Asynchronous reset mid-operation discards everything at once
    set_alloc(1'b1, 32'd500, 5'd9, 6'd54, 6'd9, 1'b1, 1'b0); step();
    set_alloc(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_head_num", head_instr_num, 32'd0);
    RESET = 1'b1;
    step();
    chk("arst_after_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
